// File: rtl/usb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// usb_tx_sequencer
//
// Purpose: sequences one USB packet (SYNC, PID, DATA bytes, EOP, J idle) as an
// NRZ bit stream towards the NRZI encoder. One bit is emitted every 8 clocks.
// The bit divider starts when tx_start is accepted.
//
// Optional feature macro: TX_BITSTUFF_EN
//   defined   -> a stuffed 0 is inserted after six consecutive transmitted 1s
//                in the SYNC, PID and DATA fields.
//   undefined -> no stuffing. The packet lasts (16 + 8*count) + 3 bit times.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   synchronous active-low reset
//   tx_start     in   one-cycle packet request (only honoured in IDLE)
//   tx_pid[3:0]  in   PID nibble, latched with tx_start
//   tx_count[6:0]in   payload byte count, latched with tx_start (saturates at 64)
//   tx_data[7:0] in   current payload byte from the TX buffer
//   packet_done  in   encoder EOP acknowledge (informational only)
//   get_tx_data  out  pop strobe to the TX buffer
//   serial_out   out  NRZ bit to the encoder
//   shift_enable out  bit-time strobe to the encoder
//   eop_flag     out  SE0 request
//   reset_out    out  force-J request
//   tx_busy      out  high whenever not IDLE
//   tx_done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module usb_tx_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_count,
  input  logic [7:0] tx_data,
  input  logic       packet_done,
  output logic       get_tx_data,
  output logic       serial_out,
  output logic       shift_enable,
  output logic       eop_flag,
  output logic       reset_out,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_PID   = 3'd2,
    S_DATA  = 3'd3,
    S_EOP   = 3'd4,
    S_JIDLE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] MAX_BYTES = 7'd64;

  // PID byte carries the nibble in the low half and its complement in the high half
  function automatic logic [7:0] f_pid_byte(input logic [3:0] pid);
    f_pid_byte = {~pid, pid};
  endfunction

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_div;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [3:0] r_pid;
  logic [6:0] r_bytes_left;
  logic       r_serial;

  logic       w_strobe;
  logic       w_in_field;
  logic       w_advance;
  logic       w_stuff_now;
  logic       w_pop;
  logic [2:0] w_next_idx;
  logic [7:0] w_pid_byte;
  logic       w_unused_ack;

  // The EOP acknowledge is not allowed to influence sequencing.
  assign w_unused_ack = packet_done;

  assign w_strobe   = (r_state != S_IDLE) && (r_state != S_DONE) && (r_div == 3'd7);
  assign w_in_field = (r_state == S_SYNC) || (r_state == S_PID) || (r_state == S_DATA);
  assign w_next_idx = r_bit_idx + 3'd1;
  assign w_pid_byte = f_pid_byte(r_pid);

`ifdef TX_BITSTUFF_EN
  logic [2:0] r_ones;
  logic       r_stuff;

  // The sixth consecutive 1 is ending now: the next bit time is a stuffed 0
  // and the bit index / field do not advance until that bit time completes.
  assign w_stuff_now = w_strobe && w_in_field && !r_stuff && r_serial && (r_ones == 3'd5);
  assign w_advance   = w_strobe && !w_stuff_now;

  // Consecutive-ones counter and stuffed-bit marker
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_ones  <= 3'd0;
      r_stuff <= 1'b0;
    end else if (!w_in_field) begin
      r_ones  <= 3'd0;
      r_stuff <= 1'b0;
    end else if (w_stuff_now) begin
      r_ones  <= 3'd0;
      r_stuff <= 1'b1;
    end else if (w_advance) begin
      r_stuff <= 1'b0;
      if (r_serial && !r_stuff) begin
        r_ones <= r_ones + 3'd1;
      end else begin
        r_ones <= 3'd0;
      end
    end
  end
`else
  assign w_stuff_now = 1'b0;
  assign w_advance   = w_strobe;
`endif

  // A pop happens on the edge that loads a payload byte's first bit
  assign w_pop = w_advance && (r_bit_idx == 3'd7) &&
                 ((r_state == S_PID) || (r_state == S_DATA)) &&
                 (r_bytes_left != 7'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (tx_start) begin
          w_next_state = S_SYNC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SYNC: begin
        if (w_advance && (r_bit_idx == 3'd7)) begin
          w_next_state = S_PID;
        end else begin
          w_next_state = S_SYNC;
        end
      end
      S_PID, S_DATA: begin
        if (w_advance && (r_bit_idx == 3'd7)) begin
          if (r_bytes_left == 7'd0) begin
            w_next_state = S_EOP;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = r_state;
        end
      end
      S_EOP: begin
        // Two bit times of SE0: r_bit_idx counts them
        if (w_strobe && (r_bit_idx == 3'd1)) begin
          w_next_state = S_JIDLE;
        end else begin
          w_next_state = S_EOP;
        end
      end
      S_JIDLE: begin
        if (w_strobe) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_JIDLE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bit divider, bit position, shift byte and serial bit
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_div        <= 3'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_pid        <= 4'h0;
      r_bytes_left <= 7'd0;
      r_serial     <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_div <= 3'd0;
      end else begin
        r_div <= r_div + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_bit_idx <= 3'd0;
          if (tx_start) begin
            r_pid        <= tx_pid;
            r_bytes_left <= (tx_count > MAX_BYTES) ? MAX_BYTES : tx_count;
            r_shift      <= SYNC_BYTE;
            r_serial     <= SYNC_BYTE[0];
          end else begin
            r_serial <= 1'b1;
          end
        end
        S_SYNC, S_PID, S_DATA: begin
          if (w_stuff_now) begin
            r_serial <= 1'b0;
          end else if (w_advance) begin
            if (r_bit_idx != 3'd7) begin
              r_bit_idx <= w_next_idx;
              r_serial  <= r_shift[w_next_idx];
            end else begin
              r_bit_idx <= 3'd0;
              if (r_state == S_SYNC) begin
                r_shift  <= w_pid_byte;
                r_serial <= w_pid_byte[0];
              end else if (r_bytes_left != 7'd0) begin
                r_shift      <= tx_data;
                r_serial     <= tx_data[0];
                r_bytes_left <= r_bytes_left - 7'd1;
              end else begin
                // Heading into EOP: line level is don't-care under SE0, keep it high
                r_serial <= 1'b1;
              end
            end
          end
        end
        S_EOP: begin
          r_serial <= 1'b1;
          if (w_strobe) begin
            r_bit_idx <= (r_bit_idx == 3'd0) ? 3'd1 : 3'd0;
          end
        end
        S_JIDLE, S_DONE: begin
          r_serial  <= 1'b1;
          r_bit_idx <= 3'd0;
        end
        default: begin
          r_serial  <= 1'b1;
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    get_tx_data  = 1'b0;
    shift_enable = 1'b0;
    eop_flag     = 1'b0;
    reset_out    = 1'b0;
    tx_busy      = 1'b1;
    tx_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        reset_out = 1'b1;
        tx_busy   = 1'b0;
      end
      S_SYNC, S_PID, S_DATA: begin
        shift_enable = w_strobe;
        get_tx_data  = w_pop;
      end
      S_EOP: begin
        shift_enable = w_strobe;
        eop_flag     = 1'b1;
      end
      S_JIDLE: begin
        shift_enable = w_strobe;
        reset_out    = 1'b1;
      end
      S_DONE: begin
        reset_out = 1'b1;
        tx_done   = 1'b1;
      end
      default: begin
        reset_out = 1'b1;
        tx_busy   = 1'b0;
      end
    endcase
  end

  assign serial_out = r_serial;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_sequencer: self-checking bench. A per-bit-time model of each
// packet (bit value, EOP, J, first-bit-of-byte) is built from the packet
// rules. Every cycle is then compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_count;
  logic [7:0] tx_data;
  logic       packet_done;
  logic       get_tx_data;
  logic       serial_out;
  logic       shift_enable;
  logic       eop_flag;
  logic       reset_out;
  logic       tx_busy;
  logic       tx_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] pay_mem [0:69];
  int         ptr;
  int         npops;

  logic exp_bit   [0:1023];
  logic exp_eop   [0:1023];
  logic exp_j     [0:1023];
  logic exp_first [0:1024];
  int   nb;
  int   ones;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .tx_pid       (tx_pid),
    .tx_count     (tx_count),
    .tx_data      (tx_data),
    .packet_done  (packet_done),
    .get_tx_data  (get_tx_data),
    .serial_out   (serial_out),
    .shift_enable (shift_enable),
    .eop_flag     (eop_flag),
    .reset_out    (reset_out),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Append one transmitted bit; insert a stuffed 0 after six 1s when enabled
  task automatic push_bit(input logic b, input logic first);
    exp_bit[nb] = b; exp_eop[nb] = 1'b0; exp_j[nb] = 1'b0; exp_first[nb] = first;
    nb++;
`ifdef TX_BITSTUFF_EN
    if (b) ones++; else ones = 0;
    if (ones == 6) begin
      exp_bit[nb] = 1'b0; exp_eop[nb] = 1'b0; exp_j[nb] = 1'b0; exp_first[nb] = 1'b0;
      nb++;
      ones = 0;
    end
`endif
  endtask

  task automatic build_model(input logic [3:0] pid, input int nbytes);
    logic [7:0] v;
    nb = 0;
    ones = 0;
    v = 8'h80;
    for (int i = 0; i < 8; i++) push_bit(v[i], 1'b0);
    v = {~pid, pid};
    for (int i = 0; i < 8; i++) push_bit(v[i], 1'b0);
    for (int k = 0; k < nbytes; k++) begin
      v = pay_mem[k];
      for (int i = 0; i < 8; i++) push_bit(v[i], (i == 0));
    end
    for (int e = 0; e < 2; e++) begin
      exp_bit[nb] = 1'b1; exp_eop[nb] = 1'b1; exp_j[nb] = 1'b0; exp_first[nb] = 1'b0;
      nb++;
    end
    exp_bit[nb] = 1'b1; exp_eop[nb] = 1'b0; exp_j[nb] = 1'b1; exp_first[nb] = 1'b0;
    nb++;
    exp_first[nb] = 1'b0;
  endtask

  // Send one packet and check every cycle. restart_cyc re-asserts tx_start
  // in that cycle; stop_cyc>0 ends checking early (for the mid-packet reset).
  task automatic run_packet(input logic [3:0] pid, input logic [6:0] cnt, input int restart_cyc,
                            input bit pd_hold0, input int stop_cyc, input string name);
    int sat;
    int last;
    int b;
    int p;
    sat = (cnt > 7'd64) ? 64 : int'(cnt);
    build_model(pid, sat);
    @(negedge clk);
    tx_pid = pid; tx_count = cnt; tx_start = 1'b1;
    ptr = 0; tx_data = pay_mem[0]; npops = 0; packet_done = 1'b0;
    @(posedge clk);
    last = (stop_cyc > 0) ? stop_cyc : 8 * nb + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      tx_start = (c == restart_cyc);
      b = (c - 1) / 8;
      p = (c - 1) % 8;
      if (c <= 8 * nb) begin
        chk({name, ".serial"}, serial_out, exp_bit[b]);
        chk({name, ".shift"},  shift_enable, (p == 7));
        chk({name, ".eop"},    eop_flag, exp_eop[b]);
        chk({name, ".rstout"}, reset_out, exp_j[b]);
        chk({name, ".pop"},    get_tx_data, (p == 7) && exp_first[b + 1]);
        chk({name, ".busy"},   tx_busy, 1'b1);
        chk({name, ".done"},   tx_done, 1'b0);
      end else if (c == 8 * nb + 1) begin
        chk({name, ".done_pulse"}, tx_done, 1'b1);
        chk({name, ".done_busy"},  tx_busy, 1'b1);
        chk({name, ".done_shift"}, shift_enable, 1'b0);
        chk({name, ".done_pop"},   get_tx_data, 1'b0);
        chk({name, ".done_eop"},   eop_flag, 1'b0);
      end else begin
        chk({name, ".idle_busy"},   tx_busy, 1'b0);
        chk({name, ".idle_done"},   tx_done, 1'b0);
        chk({name, ".idle_serial"}, serial_out, 1'b1);
        chk({name, ".idle_rstout"}, reset_out, 1'b1);
        chk({name, ".idle_shift"},  shift_enable, 1'b0);
      end
      packet_done = pd_hold0 ? 1'b0 : (eop_flag & shift_enable);
      if (get_tx_data) begin
        npops++;
        @(posedge clk);
        #1;
        ptr++;
        if (ptr < 70) tx_data = pay_mem[ptr];
      end
    end
    tx_start = 1'b0;
    packet_done = 1'b0;
    if (stop_cyc == 0) chk({name, ".pops"}, npops, sat);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pay_mem[i] = 8'($urandom);
  endtask

  initial begin
    n_rst = 1'b0; tx_start = 1'b0; tx_pid = 4'h0; tx_count = 7'd0;
    tx_data = 8'h00; packet_done = 1'b0;
    for (int i = 0; i < 70; i++) pay_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", tx_busy, 1'b0);
    chk("rst.serial", serial_out, 1'b1);
    chk("rst.rstout", reset_out, 1'b1);
    chk("rst.shift", shift_enable, 1'b0);
    chk("rst.eop", eop_flag, 1'b0);
    chk("rst.pop", get_tx_data, 1'b0);
    chk("rst.done", tx_done, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle.busy", tx_busy, 1'b0);

    // ACK: no payload, encoder acknowledges EOP
    run_packet(4'h2, 7'd0, 0, 1'b0, 0, "ack");

    // DATA0 with 8'h00, 8'hFF
    pay_mem[0] = 8'h00; pay_mem[1] = 8'hFF;
    run_packet(4'h3, 7'd2, 0, 1'b0, 0, "data0");

    // tx_start re-asserted mid-DATA must be ignored
    fill_random(3);
    run_packet(4'hB, 7'd3, 8 * 20 + 3, 1'b0, 0, "restart");

    // Count saturation
    fill_random(70);
    run_packet(4'h3, 7'd70, 0, 1'b0, 0, "sat70");

    // EOP acknowledge never arrives
    run_packet(4'h2, 7'd0, 0, 1'b1, 0, "ack_nopd");

    // Random packets
    for (int r = 0; r < 5; r++) begin
      fill_random(12);
      run_packet(4'($urandom_range(0, 15)), 7'($urandom_range(0, 12)), 0,
                 1'($urandom_range(0, 1)), 0, "rand");
    end

    // Reset in the middle of DATA
    fill_random(4);
    run_packet(4'h3, 7'd4, 0, 1'b0, 170, "rstmid");
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("rstmid.busy", tx_busy, 1'b0);
    chk("rstmid.serial", serial_out, 1'b1);
    chk("rstmid.rstout", reset_out, 1'b1);
    chk("rstmid.eop", eop_flag, 1'b0);
    chk("rstmid.pop", get_tx_data, 1'b0);
    chk("rstmid.shift", shift_enable, 1'b0);
    chk("rstmid.done", tx_done, 1'b0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("rstmid.after_pop", get_tx_data, 1'b0);
      chk("rstmid.after_busy", tx_busy, 1'b0);
    end

    // Recovery after reset
    fill_random(2);
    run_packet(4'h9, 7'd2, 0, 1'b0, 0, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
